// File: rtl/gpio_coeff_bank_pkg.sv
// Shared register offsets, GPIO field positions and playback state type for the coefficient bank.
package gpio_regs_pkg;

    localparam logic [1:0] WR_OFS  = 2'd0;
    localparam logic [1:0] RD_OFS  = 2'd1;
    localparam logic [1:0] CLR_OFS = 2'd2;
    localparam logic [1:0] RPR_OFS = 2'd3;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned ADDR_MSB = 23;
    localparam int unsigned STB_BIT  = 31;

    typedef enum logic {IDLE, RUN} play_state_t;

endpackage

// File: rtl/gpio_coeff_bank_if.sv
// GPIO register bus plus the per-channel DAC AXI-Stream outputs of the coefficient bank.
interface gpio_coeff_bank_if #(
    parameter int NUM_CH  = 3,
    parameter int TDATA_W = 256
);
    logic [31:0]               gpio_in;
    logic [31:0]               gpio_out_bus;
    logic [NUM_CH*TDATA_W-1:0] m_axis_tdata;
    logic [NUM_CH-1:0]         m_axis_tvalid;
    logic [NUM_CH-1:0]         m_axis_tready;
    logic                      busy;

    modport master (
        output gpio_in, m_axis_tready,
        input  gpio_out_bus, m_axis_tdata, m_axis_tvalid, busy
    );

    modport slave (
        input  gpio_in, m_axis_tready,
        output gpio_out_bus, m_axis_tdata, m_axis_tvalid, busy
    );
endinterface

// File: rtl/gpio_coeff_bank_channel.sv
// One coefficient channel: word memory, load/readback pointers and the AXIS beat sequencer.
module coeff_channel #(
    parameter  int DEPTH   = 16,
    parameter  int WORD_W  = 16,
    parameter  int TDATA_W = 256,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_byte,
    input  logic               rd_cmd,
    input  logic               clr,
    input  logic               rpr,
    input  logic               start,
    input  logic [7:0]         data,
    input  logic               tready,
    output logic [WORD_W-1:0]  rd_word,
    output logic [LW-1:0]      len,
    output logic               phase,
    output logic               ovf,
    output logic               tvalid,
    output logic               done_next,
    output logic [TDATA_W-1:0] tdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, beat_k, play_addr;
    logic [LW-1:0]     plen;
    logic [7:0]        hi;
    logic [WORD_W-1:0] beat;
    logic              pend, fire, last;

    assign fire      = tvalid & tready;
    assign last      = ({1'b0, beat_k} == plen - 1'b1);
    // Look one word ahead on a handshake so the next beat is ready the following cycle.
    assign play_addr = fire ? beat_k + 1'b1 : beat_k;
    assign done_next = (!tvalid && !pend) || (fire && last);
    assign tdata     = {(TDATA_W/WORD_W){beat}};

    always_ff @(posedge clk) begin
        if (wr_byte && phase)
            mem[wr_ptr] <= WORD_W'({hi, data});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len     <= '0;
            phase   <= 1'b0;
            ovf     <= 1'b0;
            hi      <= '0;
            rd_word <= '0;
            beat    <= '0;
            beat_k  <= '0;
            plen    <= '0;
            pend    <= 1'b0;
            tvalid  <= 1'b0;
        end else begin
            beat <= mem[play_addr];
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                len    <= '0;
                phase  <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                if (wr_byte) begin
                    if (!phase) begin
                        hi    <= data;
                        phase <= 1'b1;
                    end else begin
                        phase  <= 1'b0;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == AW'(DEPTH - 1))
                            ovf <= 1'b1;
                        if (len != LW'(DEPTH))
                            len <= len + 1'b1;
                    end
                end
                if (rd_cmd) begin
                    rd_word <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + 1'b1;
                end else if (rpr) begin
                    rd_ptr <= '0;
                end
            end
            // A restart on the final handshake must not leave the old last beat valid.
            if (start) begin
                plen   <= len;
                beat_k <= '0;
                pend   <= (len != '0);
                tvalid <= 1'b0;
            end else if (pend) begin
                pend   <= 1'b0;
                tvalid <= 1'b1;
            end else if (fire) begin
                if (last)
                    tvalid <= 1'b0;
                else
                    beat_k <= beat_k + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpio_coeff_bank.sv
// NUM_CH-channel coefficient store loaded over the GPIO strobe bus and replayed onto AXIS.
//  state | meaning
//  IDLE  | commands accepted, no channel streaming
//  RUN   | at least one channel streaming; WRITE/CLEAR/PLAY ignored
module gpio_coeff_bank
    import gpio_regs_pkg::*;
#(
    parameter int          NUM_CH    = 3,
    parameter int          DEPTH     = 16,
    parameter int          WORD_W    = 16,
    parameter int          TDATA_W   = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0
) (
    input  logic             clk,
    input  logic             rst,
    gpio_coeff_bank_if.slave bus
);
    localparam int          LW       = $clog2(DEPTH) + 1;
    localparam int          CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] PLAY_OFS = 16'(NUM_CH * 4);

    logic                             s1, s2, s3, stb_edge;
    logic [15:0]                      addr, off;
    logic [7:0]                       data;
    logic [CW-1:0]                    ch, rd_sel, last_ch;
    logic [1:0]                       kofs;
    logic                             hit_ch, hit_play, run_eff, all_done, any_len, start;
    logic                             rd_pend, busy;
    logic [NUM_CH-1:0]                wr_byte, rd_cmd, clr, rpr, phase, ovf, done_next, tvalid;
    logic [NUM_CH-1:0][TDATA_W-1:0]   tdata;
    logic [NUM_CH-1:0][WORD_W-1:0]    rd_word;
    logic [NUM_CH-1:0][LW-1:0]        len;
    logic [7:0]                       ovf8;
    logic [31:0]                      out_bus;
    logic                             unused_bits;
    play_state_t                      state;

    assign unused_bits = ^bus.gpio_in[30:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.gpio_in[STB_BIT];
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign stb_edge = s2 & ~s3;
    assign addr     = bus.gpio_in[ADDR_MSB:ADDR_LSB];
    assign data     = bus.gpio_in[DATA_MSB:DATA_LSB];
    assign off      = addr - BASE_ADDR;
    assign ch       = off[CW+1:2];
    assign kofs     = off[1:0];
    assign hit_ch   = stb_edge && (off < PLAY_OFS);
    assign hit_play = stb_edge && (off == PLAY_OFS);
    assign all_done = &done_next;
    // A strobe landing on the final handshake sees the post-handshake (idle) state.
    assign run_eff  = (state == RUN) && !all_done;
    assign start    = hit_play && !run_eff;

    always_comb begin
        any_len = 1'b0;
        wr_byte = '0;
        rd_cmd  = '0;
        clr     = '0;
        rpr     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            any_len    = any_len | (len[c] != '0);
            wr_byte[c] = hit_ch && (ch == CW'(c)) && (kofs == WR_OFS) && !run_eff;
            rd_cmd[c]  = hit_ch && (ch == CW'(c)) && (kofs == RD_OFS);
            clr[c]     = hit_ch && (ch == CW'(c)) && (kofs == CLR_OFS) && !run_eff;
            rpr[c]     = hit_ch && (ch == CW'(c)) && (kofs == RPR_OFS);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        coeff_channel #(
            .DEPTH   (DEPTH),
            .WORD_W  (WORD_W),
            .TDATA_W (TDATA_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_byte   (wr_byte[g]),
            .rd_cmd    (rd_cmd[g]),
            .clr       (clr[g]),
            .rpr       (rpr[g]),
            .start     (start),
            .data      (data),
            .tready    (bus.m_axis_tready[g]),
            .rd_word   (rd_word[g]),
            .len       (len[g]),
            .phase     (phase[g]),
            .ovf       (ovf[g]),
            .tvalid    (tvalid[g]),
            .done_next (done_next[g]),
            .tdata     (tdata[g])
        );
    end

    for (genvar g = 0; g < 8; g++) begin : g_ovf
        if (g < NUM_CH) begin : g_on
            assign ovf8[g] = ovf[g];
        end else begin : g_off
            assign ovf8[g] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && any_len) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (start && any_len) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else if (all_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_sel  <= '0;
            last_ch <= '0;
            out_bus <= '0;
        end else begin
            rd_pend <= |rd_cmd;
            if (hit_ch)
                last_ch <= ch;
            if (|rd_cmd)
                rd_sel <= ch;
            if (rd_pend)
                out_bus[15:0] <= 16'(rd_word[rd_sel]);
            out_bus[31:16] <= {6'b0, phase[last_ch], busy, ovf8};
        end
    end

    assign bus.gpio_out_bus  = out_bus;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_gpio_coeff_bank.sv
// Scoreboard bench for gpio_coeff_bank: directed GPIO commands, queued expected beats/reads.
module tb_gpio_coeff_bank;
    import gpio_regs_pkg::*;

    localparam int          NUM_CH  = 3;
    localparam int          DEPTH   = 16;
    localparam int          TDATA_W = 256;
    localparam logic [15:0] PLAY_A  = 16'd12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_coeff_bank_if #(.NUM_CH(NUM_CH), .TDATA_W(TDATA_W)) bus ();

    gpio_coeff_bank #(
        .NUM_CH    (NUM_CH),
        .DEPTH     (DEPTH),
        .WORD_W    (16),
        .TDATA_W   (TDATA_W),
        .BASE_ADDR (16'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int rmode = 0;
    int rcyc = 0;

    logic [15:0]       m_mem [NUM_CH][DEPTH];
    int                m_len [NUM_CH];
    int                m_wr  [NUM_CH];
    int                m_rd  [NUM_CH];
    logic [15:0]       exp_q [NUM_CH][$];
    logic [15:0]       rd_q  [$];
    event              rd_ev;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Ready pattern: 0 = always ready, 1 = repeating 1,0,0,1, 2 = held low.
    always @(posedge clk) begin
        #1;
        rcyc++;
        case (rmode)
            0:       bus.m_axis_tready = '1;
            1:       bus.m_axis_tready = ((rcyc % 4 == 0) || (rcyc % 4 == 3)) ? '1 : '0;
            default: bus.m_axis_tready = '0;
        endcase
    end

    logic [NUM_CH-1:0] pv, pr;
    logic [TDATA_W-1:0] pd [NUM_CH];

    always @(negedge clk) begin
        if (!rst) begin
            pv <= '0;
            pr <= '0;
        end else begin
            if (bus.busy)
                busy_cnt <= busy_cnt + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                logic [15:0]  w;
                logic [255:0] e;
                if (pv[c] && !pr[c]) begin
                    chk($sformatf("hold_valid_ch%0d", c), bus.m_axis_tvalid[c], 1'b1);
                    chk($sformatf("hold_data_ch%0d", c), bus.m_axis_tdata[c*TDATA_W +: TDATA_W], pd[c]);
                end
                if (bus.m_axis_tvalid[c] && bus.m_axis_tready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("extra_beat_ch%0d", c), bus.m_axis_tvalid[c], 1'b0);
                    end else begin
                        w = exp_q[c].pop_front();
                        e = {16{w}};
                        chk($sformatf("beat_ch%0d", c), bus.m_axis_tdata[c*TDATA_W +: TDATA_W], e);
                    end
                end
                pv[c] <= bus.m_axis_tvalid[c];
                pr[c] <= bus.m_axis_tready[c];
                pd[c] <= bus.m_axis_tdata[c*TDATA_W +: TDATA_W];
            end
        end
    end

    always begin
        @(rd_ev);
        if (rd_q.size() != 0)
            chk("read_word", bus.gpio_out_bus[15:0], rd_q.pop_front());
    end

    task automatic strobe(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.gpio_in = {1'b1, 7'd0, a, d};
        repeat (3) @(negedge clk);
        bus.gpio_in[31] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_word(input int c, input logic [15:0] w, input bit model);
        strobe(16'(c * 4) + 16'(WR_OFS), w[15:8]);
        strobe(16'(c * 4) + 16'(WR_OFS), w[7:0]);
        if (model) begin
            m_mem[c][m_wr[c]] = w;
            m_wr[c] = (m_wr[c] + 1) % DEPTH;
            if (m_len[c] < DEPTH)
                m_len[c]++;
        end
    endtask

    task automatic rd_word(input int c);
        rd_q.push_back(m_mem[c][m_rd[c]]);
        m_rd[c] = (m_rd[c] + 1) % DEPTH;
        strobe(16'(c * 4) + 16'(RD_OFS), 8'h00);
        @(negedge clk);
        -> rd_ev;
        @(negedge clk);
    endtask

    task automatic clear(input int c);
        strobe(16'(c * 4) + 16'(CLR_OFS), 8'h00);
        m_wr[c] = 0;
        m_rd[c] = 0;
        m_len[c] = 0;
    endtask

    task automatic play_start();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < m_len[c]; k++)
                exp_q[c].push_back(m_mem[c][k]);
        strobe(PLAY_A, 8'h00);
    endtask

    task automatic play_wait();
        for (int i = 0; i < 400 && bus.busy; i++)
            @(negedge clk);
        chk("play_done", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("beats_left_ch%0d", c), exp_q[c].size(), 0);
    endtask

    initial begin
        int b0;
        bus.gpio_in = '0;
        bus.m_axis_tready = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_len[c] = 0;
            m_wr[c] = 0;
            m_rd[c] = 0;
        end

        #3 rst = 1'b0;
        #20;
        chk("rst_gpio_out", bus.gpio_out_bus, 32'h0);
        chk("rst_tvalid", bus.m_axis_tvalid, 3'b000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_tdata", bus.m_axis_tdata[255:0], 256'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_gpio_out", bus.gpio_out_bus, 32'h0);

        // Fill ch0 with 0..15; the 16th write wraps wr_ptr and sets ovf0.
        for (int i = 0; i < 16; i++)
            wr_word(0, 16'(i), 1'b1);
        chk("status_after_fill", bus.gpio_out_bus, 32'h0001_0000);
        strobe(16'd8, 8'h12);
        chk("status_half_word", bus.gpio_out_bus, 32'h0201_0000);
        clear(2);
        chk("status_after_clr2", bus.gpio_out_bus, 32'h0001_0000);

        for (int i = 0; i < 17; i++)
            rd_word(0);

        clear(0);
        chk("status_after_clr0", bus.gpio_out_bus[31:16], 16'h0000);
        for (int n = 0; n < 5; n++)
            wr_word(2, 16'h1234 + 16'(n), 1'b1);
        b0 = busy_cnt;
        play_start();
        play_wait();
        chk("busy_cycles", busy_cnt - b0, 6);

        rmode = 1;
        play_start();
        play_wait();
        rmode = 0;

        rmode = 2;
        play_start();
        chk("busy_in_run", bus.busy, 1'b1);
        wr_word(2, 16'hDEAD, 1'b0);
        strobe(16'd8 + 16'(CLR_OFS), 8'h00);
        chk("phase_in_run", bus.gpio_out_bus[25], 1'b0);
        rmode = 0;
        play_wait();
        play_start();
        play_wait();

        clear(2);
        b0 = busy_cnt;
        play_start();
        repeat (6) @(negedge clk);
        chk("busy_no_len", busy_cnt - b0, 0);

        for (int n = 0; n < 3; n++)
            wr_word(2, 16'hA5A5, 1'b1);
        rmode = 2;
        play_start();
        for (int i = 0; i < 20 && !bus.m_axis_tvalid[2]; i++)
            @(negedge clk);
        chk("valid_before_rst", bus.m_axis_tvalid[2], 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_run_tvalid", bus.m_axis_tvalid, 3'b000);
        chk("rst_run_busy", bus.busy, 1'b0);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            m_wr[c] = 0;
            m_rd[c] = 0;
            m_len[c] = 0;
        end
        rmode = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        clear(0);
        chk("status_after_rst_clr", bus.gpio_out_bus, 32'h0);
        b0 = busy_cnt;
        play_start();
        repeat (6) @(negedge clk);
        chk("busy_len0_after_rst", busy_cnt - b0, 0);
        rd_word(2);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
